// File: rtl/otprom_pkg.sv
// otprom_pkg: shared widths, index-width helper and FSM state types for the OTP-PROM slice
package otprom_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  typedef enum logic {AG_IDLE, AG_PROG} agent_state_t;
  typedef enum logic [1:0] {BT_IDLE, BT_SWEEP, BT_DONE} boot_state_t;
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/otprom_if.sv
// otprom_if: write request and array read port between the top-level bus and the program agent
interface otprom_if #(parameter int IW = 6);
  import otprom_pkg::*;
  logic wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [IW-1:0] ridx;
  logic [DATA_W-1:0] rword;
  modport master(output wen, waddr, wdata, ridx, input rword);
  modport slave(input wen, waddr, wdata, ridx, output rword);
endinterface

// File: rtl/otprom_agent.sv
// otprom_agent: OTP word array with program-pulse sequencer; writes OR into the stored word.
// Build with OTPROM_LOCK_EN to make bit 0 of the last word a permanent write lock.
module otprom_agent import otprom_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int PROG_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  otprom_if.slave bus
);
  localparam int IW = idx_w(DEPTH);
  localparam int CW = idx_w(PROG_CYCLES);
  // sized to a power of two so any index is legal; only the first DEPTH words are writable
  logic [DATA_W-1:0] mem [2**IW];
  agent_state_t state, state_n;
  logic [IW-1:0] widx;
  logic [DATA_W-1:0] wdat;
  logic [CW-1:0] cnt;
  logic locked, accept, commit, timing, busy, unused_waddr;
`ifdef OTPROM_LOCK_EN
  assign locked = mem[DEPTH-1][0];
`else
  assign locked = 1'b0;
`endif
  assign unused_waddr = ^bus.waddr[1:0];
  assign accept = state == AG_IDLE && bus.wen && !locked && bus.waddr[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH);
  assign commit = state == AG_PROG && cnt == CW'(PROG_CYCLES-1);
  assign timing = state == AG_PROG;
  assign busy = timing;
  assign bus.rword = mem[bus.ridx];
  always_comb begin
    state_n = state;
    state_n = accept ? AG_PROG : commit ? AG_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AG_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= timing && !commit ? cnt + 1'b1 : '0;
    end
    if (accept) begin
      widx <= bus.waddr[IW+1:2];
      wdat <= bus.wdata;
    end
  end
  // cells survive reset; only an uninterrupted pulse commits
  always_ff @(posedge clk) begin
    if (!reset && commit) mem[widx] <= mem[widx] | wdat;
  end
endmodule

// File: rtl/otprom_top.sv
// otprom_top: OTP-PROM cell logic with boot-read master, registered read port and program agent.
// Optional OTPROM_LOCK_EN enables the last-word lock bit inside the agent.
module otprom_top import otprom_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int PROG_CYCLES = 4,
  parameter int BOOT_WORDS = 8
) (
  input logic clk,
  input logic reset
);
  localparam int IW = idx_w(DEPTH);
  localparam int BW = idx_w(BOOT_WORDS + 1);
  logic [ADDR_W-1:0] m_ram_raddr, m_ram_waddr;
  logic [DATA_W-1:0] m_ram_wdata, m_ram_rdata, boot_sum;
  logic m_ram_ren, m_ram_wen, m_ram_rvalid, boot_done, rd_in_range, unused_raddr;
  boot_state_t bstate, bstate_n;
  logic [BW-1:0] issue, rcnt;
  otprom_if #(.IW(IW)) bus();
  otprom_agent #(.DEPTH(DEPTH), .PROG_CYCLES(PROG_CYCLES)) u_agent (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  assign bus.wen = m_ram_wen;
  assign bus.waddr = m_ram_waddr;
  assign bus.wdata = m_ram_wdata;
  assign bus.ridx = m_ram_raddr[IW+1:2];
  assign unused_raddr = ^m_ram_raddr[1:0];
  assign rd_in_range = m_ram_raddr[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH);
  assign m_ram_wen = 1'b0;
  assign m_ram_waddr = '0;
  assign m_ram_wdata = '0;
  assign m_ram_ren = bstate == BT_SWEEP && issue < BW'(BOOT_WORDS);
  assign m_ram_raddr = ADDR_W'(issue) << 2;
  assign boot_done = bstate == BT_DONE;
  always_comb begin
    bstate_n = bstate;
    bstate_n = bstate == BT_IDLE ? BT_SWEEP :
               bstate == BT_SWEEP && m_ram_rvalid && rcnt == BW'(BOOT_WORDS-1) ? BT_DONE : bstate;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bstate <= BT_IDLE;
      issue <= '0;
      rcnt <= '0;
      boot_sum <= '0;
      m_ram_rdata <= '0;
      m_ram_rvalid <= 1'b0;
    end else begin
      bstate <= bstate_n;
      issue <= issue + BW'(m_ram_ren);
      if (bstate == BT_SWEEP && m_ram_rvalid) begin
        rcnt <= rcnt + 1'b1;
        boot_sum <= boot_sum ^ m_ram_rdata;
      end
      m_ram_rvalid <= m_ram_ren;
      if (m_ram_ren) m_ram_rdata <= rd_in_range ? bus.rword : '0;
    end
  end
endmodule

// File: tb/tb_otprom_top.sv
// tb_otprom_top: directed checks of the OTP-PROM top, driving the internal bus by force
module tb_otprom_top;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [31:0] f_raddr = '0, f_waddr = '0, f_wdata = '0;
  logic f_ren = 1'b0, f_wen = 1'b0;
  logic [31:0] rd;
  logic rv;
  int n;
  always #5 clk = ~clk;
  otprom_top dut (.clk(clk), .reset(reset));

  task bus_force;
    force dut.m_ram_raddr = f_raddr;
    force dut.m_ram_ren = f_ren;
    force dut.m_ram_waddr = f_waddr;
    force dut.m_ram_wdata = f_wdata;
    force dut.m_ram_wen = f_wen;
  endtask

  task bus_release;
    release dut.m_ram_raddr;
    release dut.m_ram_ren;
    release dut.m_ram_waddr;
    release dut.m_ram_wdata;
    release dut.m_ram_wen;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    f_waddr = a;
    f_wdata = d;
    f_wen = 1'b1;
    @(negedge clk);
    f_wen = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    f_raddr = a;
    f_ren = 1'b1;
    @(negedge clk);
    f_ren = 1'b0;
    v = dut.m_ram_rvalid;
    d = dut.m_ram_rdata;
  endtask

  task automatic count_timing(output int cnt);
    int bad;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (dut.u_agent.timing === 1'b1) cnt++;
      if (dut.u_agent.busy !== dut.u_agent.timing) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL busy_eq_timing: busy differed from timing in %0d cycles, required 0", bad);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({dut.u_agent.timing, dut.u_agent.busy, dut.m_ram_rvalid, dut.boot_done, dut.m_ram_ren} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags: timing/busy/rvalid/done/ren=%b required 00000",
               {dut.u_agent.timing, dut.u_agent.busy, dut.m_ram_rvalid, dut.boot_done, dut.m_ram_ren});
    end
    checks++;
    if ({dut.m_ram_rdata, dut.boot_sum, dut.m_ram_raddr} !== 96'h0) begin
      errs++;
      $display("FAIL reset_data: rdata=%h boot_sum=%h raddr=%h required 0", dut.m_ram_rdata, dut.boot_sum, dut.m_ram_raddr);
    end
    bus_force();
    reset = 1'b0;
  endtask

  task automatic test_idle_bus;
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dut.u_agent.timing !== 1'b0 || dut.m_ram_rvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL idle_bus: timing/rvalid active in %0d cycles, required 0", bad);
    end
    for (int i = 0; i < 64; i++) begin
      do_read(32'(i) * 4, rd, rv);
      checks++;
      if (rd !== 32'h0 || rv !== 1'b1) begin
        errs++;
        $display("FAIL blank_word%0d: rdata=%h rvalid=%b required 00000000/1", i, rd, rv);
      end
    end
  endtask

  task automatic test_write;
    do_write(32'h8, 32'hF0);
    count_timing(n);
    checks++;
    if (n != 4) begin
      errs++;
      $display("FAIL pulse_len: timing high %0d cycles required 4", n);
    end
    do_read(32'h8, rd, rv);
    checks++;
    if (rd !== 32'hF0 || rv !== 1'b1) begin
      errs++;
      $display("FAIL read_f0: rdata=%h rvalid=%b required 000000f0/1", rd, rv);
    end
    @(negedge clk);
    checks++;
    if (dut.m_ram_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL rvalid_pulse: rvalid=%b required 0", dut.m_ram_rvalid);
    end
  endtask

  task automatic test_or_only;
    do_write(32'h8, 32'h0F);
    count_timing(n);
    do_write(32'h8, 32'h00);
    count_timing(n);
    do_read(32'h8, rd, rv);
    checks++;
    if (rd !== 32'hFF) begin
      errs++;
      $display("FAIL or_merge: rdata=%h required 000000ff", rd);
    end
  endtask

  task automatic test_drops;
    do_write(32'h14, 32'h1);
    do_write(32'h10, 32'hAA);
    repeat (8) @(negedge clk);
    do_read(32'h10, rd, rv);
    checks++;
    if (rd !== 32'h0) begin
      errs++;
      $display("FAIL busy_drop: rdata=%h required 00000000", rd);
    end
    do_read(32'h14, rd, rv);
    checks++;
    if (rd !== 32'h1) begin
      errs++;
      $display("FAIL first_kept: rdata=%h required 00000001", rd);
    end
    do_read(32'h400, rd, rv);
    checks++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      errs++;
      $display("FAIL oor_read: rdata=%h rvalid=%b required 00000000/1", rd, rv);
    end
    do_write(32'h400, 32'h5);
    count_timing(n);
    checks++;
    if (n != 0) begin
      errs++;
      $display("FAIL oor_write: timing high %0d cycles required 0", n);
    end
  endtask

  task automatic test_reset_mid_pulse;
    do_write(32'h4, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.u_agent.timing !== 1'b0) begin
      errs++;
      $display("FAIL abort_timing: timing=%b required 0", dut.u_agent.timing);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    do_read(32'h4, rd, rv);
    checks++;
    if (rd !== 32'h0) begin
      errs++;
      $display("FAIL abort_word: rdata=%h required 00000000", rd);
    end
  endtask

  task automatic test_boot;
    logic [31:0] vals [8] = '{32'h11111111, 32'h22220000, 32'h00000F00, 32'h00003300,
                              32'hA5A5A5A5, 32'h5A000000, 32'h12345678, 32'h80000001};
    logic [31:0] fin [8] = '{32'h11111111, 32'h22220000, 32'h00000FFF, 32'h00003300,
                             32'hA5A5A5A5, 32'h5A000001, 32'h12345678, 32'h80000001};
    logic [31:0] sum = '0;
    for (int i = 0; i < 8; i++) begin
      do_write(32'(i) * 4, vals[i]);
      repeat (6) @(negedge clk);
      sum ^= fin[i];
    end
    reset = 1'b1;
    f_raddr = '0; f_waddr = '0; f_wdata = '0; f_ren = 1'b0; f_wen = 1'b0;
    @(negedge clk);
    bus_release();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.m_ram_ren !== 1'b1 || dut.m_ram_raddr !== 32'h0 || dut.m_ram_wen !== 1'b0) begin
      errs++;
      $display("FAIL boot_start: ren=%b raddr=%h wen=%b required 1/00000000/0", dut.m_ram_ren, dut.m_ram_raddr, dut.m_ram_wen);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (dut.boot_done !== 1'b0) begin
      errs++;
      $display("FAIL boot_early: boot_done=%b required 0 after 9 cycles", dut.boot_done);
    end
    @(negedge clk);
    checks++;
    if (dut.boot_done !== 1'b1 || dut.boot_sum !== sum) begin
      errs++;
      $display("FAIL boot_done: done=%b sum=%h required 1/%h", dut.boot_done, dut.boot_sum, sum);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dut.boot_done !== 1'b1 || dut.boot_sum !== sum) begin
      errs++;
      $display("FAIL boot_hold: done=%b sum=%h required 1/%h", dut.boot_done, dut.boot_sum, sum);
    end
  endtask

  task automatic test_lock;
    logic [31:0] exp_w0;
    int exp_n;
`ifdef OTPROM_LOCK_EN
    exp_n = 0;
    exp_w0 = 32'h11111111;
`else
    exp_n = 4;
    exp_w0 = 32'h11111113;
`endif
    bus_force();
    do_write(32'hFC, 32'h1);
    repeat (6) @(negedge clk);
    do_write(32'h0, 32'h2);
    count_timing(n);
    checks++;
    if (n != exp_n) begin
      errs++;
      $display("FAIL lock_pulse: timing high %0d cycles required %0d", n, exp_n);
    end
    do_read(32'hFC, rd, rv);
    checks++;
    if (rd !== 32'h1) begin
      errs++;
      $display("FAIL lock_word: rdata=%h required 00000001", rd);
    end
    do_read(32'h0, rd, rv);
    checks++;
    if (rd !== exp_w0) begin
      errs++;
      $display("FAIL lock_w0: rdata=%h required %h", rd, exp_w0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_bus();
    test_write();
    test_or_only();
    test_drops();
    test_reset_mid_pulse();
    test_boot();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
